// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 3x3 sliding window generator fed by two line buffers
// Shifts one pixel column per strobe and flags complete in-image neighbourhoods.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic [DATA_WIDTH-1:0]     row1_in,
    input  logic [DATA_WIDTH-1:0]     row2_in,
    output logic [9*DATA_WIDTH-1:0]   window,
    output logic                      window_valid,
    output logic                      frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [DATA_WIDTH-1:0] win_q [9];
    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic                  col_last;
    logic                  row_last;

    assign col_last = (col_cnt == CW'(IMG_WIDTH - 1));
    assign row_last = (row_cnt == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            col_cnt      <= '0;
            row_cnt      <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            // Flags are single-cycle pulses tied to the accept that produced them
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (clk_en) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                end
                win_q[2]     <= row2_in;
                win_q[5]     <= row1_in;
                win_q[8]     <= pixel_in;
                window_valid <= (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
                frame_done   <= row_last && col_last;
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign window[DATA_WIDTH*g +: DATA_WIDTH] = win_q[g];
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
// Reference model keeps the last three accepted columns and the raster position.
module tb_conv_window_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [DW-1:0] pixel_in, row1_in, row2_in;
    logic [9*DW-1:0] window;
    logic          window_valid, frame_done;

    int checks   = 0;
    int failures = 0;

    // model state: three most recent columns (index 0 oldest), raster position
    logic [DW-1:0] hist [3][3];
    int            pos;
    logic [9*DW-1:0] exp_win;
    logic          exp_valid, exp_done;

    conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .pixel_in(pixel_in), .row1_in(row1_in), .row2_in(row2_in),
        .window(window), .window_valid(window_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return (r < 0) ? '0 : DW'(16 * r + c);
    endfunction

    function automatic logic [DW-1:0] elem(input int r, input int c);
        return window[DW*(3*r+c) +: DW];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                hist[c][r] = '0;
        pos = 0;
    endtask

    task automatic cycle(input logic r_v, input logic en, input logic [DW-1:0] p,
                         input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        int row, col;
        rst = r_v; clk_en = en; pixel_in = p; row1_in = r1; row2_in = r2;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (r_v) begin
            model_clear();
        end else if (en) begin
            row = pos / W;
            col = pos % W;
            hist[0] = hist[1];
            hist[1] = hist[2];
            hist[2][0] = r2; hist[2][1] = r1; hist[2][2] = p;
            exp_valid = (row >= 2) && (col >= 2);
            exp_done  = (pos == W*H - 1);
            pos = (pos + 1) % (W*H);
        end
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                exp_win[DW*(3*r+c) +: DW] = hist[c][r];
        chk("window", window, exp_win);
        chk("window_valid", {71'd0, window_valid}, {71'd0, exp_valid});
        chk("frame_done", {71'd0, frame_done}, {71'd0, exp_done});
    endtask

    task automatic send_pixel(input int r, input int c, input int idles);
        cycle(1'b0, 1'b1, pix(r, c), pix(r-1, c), pix(r-2, c));
        if (r == 2 && c == 2) begin
            chk("centre_after_22", {64'd0, elem(1, 1)}, 72'h11);
            chk("tl_after_22", {64'd0, elem(0, 0)}, 72'h00);
            chk("br_after_22", {64'd0, elem(2, 2)}, 72'h22);
        end
        if (r == 2 && c == 3) begin
            chk("centre_after_23", {64'd0, elem(1, 1)}, 72'h12);
            chk("done_after_23", {71'd0, frame_done}, 72'd1);
        end
        for (int i = 0; i < idles; i++)
            cycle(1'b0, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    task automatic send_frame(input int idles);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(r, c, idles);
    endtask

    initial begin
        model_clear();
        exp_win = '0;
        // reset with the strobe held high
        cycle(1'b1, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        cycle(1'b1, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        chk("reset_window", window, 72'd0);
        chk("reset_valid", {71'd0, window_valid}, 72'd0);
        chk("reset_done", {71'd0, frame_done}, 72'd0);

        // continuous frame, back-to-back second frame, then sparse frame
        send_frame(0);
        send_frame(0);
        send_frame(2);

        // abandon a frame after (1,2)
        for (int k = 0; k < W + 3; k++)
            send_pixel(k / W, k % W, 0);
        cycle(1'b1, 1'b1, 8'h55, 8'h66, 8'h77);
        chk("midrst_window", window, 72'd0);
        chk("midrst_valid", {71'd0, window_valid}, 72'd0);
        chk("midrst_done", {71'd0, frame_done}, 72'd0);
        cycle(1'b0, 1'b0, 8'h01, 8'h02, 8'h03);
        send_frame(0);

        // random data, random strobe, occasional reset
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                  DW'($urandom), DW'($urandom), DW'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
